// File: rtl/mac_job_sequencer.sv
// Control-side sequencer for the MAC engine: accepts job descriptors, arms and re-arms the engine,
// counts output handshakes and pulses done_o. Optional perf counter under MAC_SEQ_PERF_CNT_EN.
module mac_job_sequencer #(
    parameter int CNT_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int ITER_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               soft_clear_i,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [CNT_W-1:0]   job_len_i,
    input  logic [SHIFT_W-1:0] job_shift_i,
    input  logic               job_simple_mul_i,
    input  logic [ITER_W-1:0]  job_iter_i,
    output logic               eng_clear_o,
    output logic               eng_enable_o,
    output logic               eng_start_o,
    output logic [CNT_W-1:0]   eng_len_o,
    output logic [SHIFT_W-1:0] eng_shift_o,
    output logic               eng_simple_mul_o,
    input  logic               d_valid_i,
    input  logic               d_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ITER_W-1:0]  iter_left_o
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   hs;
    logic   clear_dec;
    logic   done_dec;

    assign job_ready_o = (state_q == S_IDLE) & ~soft_clear_i;
    assign accept      = job_valid_i & job_ready_o;
    assign hs          = d_valid_i & d_ready_i;

    always_comb begin
        state_d      = state_q;
        clear_dec    = 1'b0;
        done_dec     = 1'b0;
        eng_enable_o = 1'b0;
        eng_start_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((job_iter_i == '0) || ((job_len_i == '0) && !job_simple_mul_i))
                        state_d = S_DONE;
                    else
                        state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_dec = 1'b1;
                state_d   = S_START;
            end
            S_START: begin
                eng_enable_o = 1'b1;
                eng_start_o  = 1'b1;
                state_d      = S_RUN;
            end
            S_RUN: begin
                eng_enable_o = 1'b1;
                // Leaving RUN after a scalar result drops enable for a cycle, so the engine's
                // re-asserted valid (counter still at len) is never counted twice.
                if (hs) begin
                    if (iter_left_o <= ITER_W'(1))
                        state_d = S_DONE;
                    else if (!eng_simple_mul_o)
                        state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                done_dec  = 1'b1;
                clear_dec = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (soft_clear_i)
            state_d = S_IDLE;
    end

    assign eng_clear_o = clear_dec | soft_clear_i;
    assign done_o      = done_dec & ~soft_clear_i;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eng_len_o        <= '0;
            eng_shift_o      <= '0;
            eng_simple_mul_o <= 1'b0;
            iter_left_o      <= '0;
        end else begin
            if (accept) begin
                eng_len_o        <= job_len_i;
                eng_shift_o      <= job_shift_i;
                eng_simple_mul_o <= job_simple_mul_i;
            end
            if (soft_clear_i)
                iter_left_o <= '0;
            else if (accept)
                iter_left_o <= job_iter_i;
            else if ((state_q == S_RUN) && hs && (iter_left_o != '0))
                iter_left_o <= iter_left_o - ITER_W'(1);
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cycles_o <= '0;
        end else if (accept) begin
            perf_cycles_o <= '0;
        end else if (eng_enable_o && (perf_cycles_o != 32'hFFFF_FFFF)) begin
            perf_cycles_o <= perf_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer: expected iter_left values are queued at job issue and
// popped on each result handshake; FSM outputs are checked against the expected sequence.
module tb_mac_job_sequencer;

    localparam int CNT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int ITER_W  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               soft_clear = 1'b0;
    logic               job_valid = 1'b0;
    logic               job_ready;
    logic [CNT_W-1:0]   job_len = '0;
    logic [SHIFT_W-1:0] job_shift = '0;
    logic               job_simple_mul = 1'b0;
    logic [ITER_W-1:0]  job_iter = '0;
    logic               eng_clear, eng_enable, eng_start;
    logic [CNT_W-1:0]   eng_len;
    logic [SHIFT_W-1:0] eng_shift;
    logic               eng_simple_mul;
    logic               d_valid = 1'b0;
    logic               d_ready = 1'b1;
    logic               busy, done;
    logic [ITER_W-1:0]  iter_left;
`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0]        perf_cycles;
`endif

    mac_job_sequencer #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W), .ITER_W(ITER_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .soft_clear_i     (soft_clear),
        .job_valid_i      (job_valid),
        .job_ready_o      (job_ready),
        .job_len_i        (job_len),
        .job_shift_i      (job_shift),
        .job_simple_mul_i (job_simple_mul),
        .job_iter_i       (job_iter),
        .eng_clear_o      (eng_clear),
        .eng_enable_o     (eng_enable),
        .eng_start_o      (eng_start),
        .eng_len_o        (eng_len),
        .eng_shift_o      (eng_shift),
        .eng_simple_mul_o (eng_simple_mul),
        .d_valid_i        (d_valid),
        .d_ready_i        (d_ready),
        .busy_o           (busy),
        .done_o           (done),
        .iter_left_o      (iter_left)
`ifdef MAC_SEQ_PERF_CNT_EN
        ,
        .perf_cycles_o    (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;
    int starts = 0;
    int en_cycles = 0;
    int dones = 0;
    logic [ITER_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts the cycle that is ending, then advances to 1 time unit past the next edge.
    task automatic tick();
        if (eng_start)  starts++;
        if (eng_enable) en_cycles++;
        if (done)       dones++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [CNT_W-1:0] len, input logic [SHIFT_W-1:0] sh,
                         input logic sm, input logic [ITER_W-1:0] it);
        job_len = len; job_shift = sh; job_simple_mul = sm; job_iter = it;
        job_valid = 1'b1;
        #1;
        check("job_ready_before_accept", {31'd0, job_ready}, 32'd1);
        tick();
        job_valid = 1'b0;
        check("eng_len_latched", {24'd0, eng_len}, {24'd0, len});
        check("eng_shift_latched", {27'd0, eng_shift}, {27'd0, sh});
        check("eng_simple_latched", {31'd0, eng_simple_mul}, {31'd0, sm});
        check("iter_left_loaded", {16'd0, iter_left}, {16'd0, it});
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, {31'd0, job_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_iter"}, {16'd0, iter_left}, 32'd0);
        check({tag, "_ctl"}, {29'd0, eng_clear, eng_enable, eng_start}, 32'd0);
        check({tag, "_len"}, {24'd0, eng_len}, 32'd0);
        check({tag, "_shift_sm"}, {26'd0, eng_shift, eng_simple_mul}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ITER_W-1:0] e;
        #1;
        check_idle_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Reset in the middle of a running job
        issue(8'd8, 5'd2, 1'b0, 16'd4);
        tick(); tick();
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_enable", {31'd0, eng_enable}, 32'd1);
        rst = 1'b1;
        #1;
        check_idle_zero("midreset");
        tick();
        rst = 1'b0;
        tick();

        // Scalar job len=4 iter=2
        starts = 0; dones = 0;
        for (int i = 1; i >= 0; i--) exp_q.push_back(ITER_W'(i));
        issue(8'd4, 5'd1, 1'b0, 16'd2);
        for (int r = 0; r < 2; r++) begin
            check("sc_clear_state", {30'd0, eng_clear, eng_enable}, 32'd2);
            tick();
            check("sc_start_state", {30'd0, eng_start, eng_enable}, 32'd3);
            tick();
            check("sc_run_state", {30'd0, eng_start, eng_enable}, 32'd1);
            tick();
            d_valid = 1'b1;
            tick();
            d_valid = 1'b0;
            e = exp_q.pop_front();
            check("sc_iter_left", {16'd0, iter_left}, {16'd0, e});
            check("sc_enable_drop", {31'd0, eng_enable}, 32'd0);
        end
        check("sc_done_after_hs", {31'd0, done}, 32'd1);
        tick();
        check("sc_done_one_cycle", {31'd0, done}, 32'd0);
        check("sc_start_count", starts, 32'd2);
        check("sc_idle_busy", {31'd0, busy}, 32'd0);

        // Simple job iter=3 with two stall cycles before each result
        starts = 0;
        for (int i = 2; i >= 0; i--) exp_q.push_back(ITER_W'(i));
        issue(8'd5, 5'd3, 1'b1, 16'd3);
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            d_valid = 1'b1; d_ready = 1'b0;
            tick(); tick();
            check("sm_stall_hold", {16'd0, iter_left}, 32'(3 - k));
            d_ready = 1'b1;
            tick();
            d_valid = 1'b0;
            e = exp_q.pop_front();
            check("sm_iter_left", {16'd0, iter_left}, {16'd0, e});
            if (k < 2) check("sm_stay_run", {30'd0, eng_clear, eng_enable}, 32'd1);
        end
        check("sm_done_after_hs", {31'd0, done}, 32'd1);
        check("sm_shift_held", {26'd0, eng_shift, eng_simple_mul}, {26'd0, 5'd3, 1'b1});
        tick();
        check("sm_start_count", starts, 32'd1);

        // Degenerate jobs: iter=0, then scalar len=0 iter=5
        starts = 0; en_cycles = 0;
        issue(8'd3, 5'd0, 1'b0, 16'd0);
        check("z_iter_done", {30'd0, done, eng_clear}, 32'd3);
        tick();
        issue(8'd0, 5'd0, 1'b0, 16'd5);
        check("z_len_done", {30'd0, done, eng_clear}, 32'd3);
        tick();
        check("z_no_start", starts, 32'd0);
        check("z_no_enable", en_cycles, 32'd0);

        // Soft clear in RUN colliding with a handshake and a new job request
        dones = 0;
        issue(8'd4, 5'd0, 1'b0, 16'd3);
        tick(); tick();
        job_len = 8'd7; job_shift = 5'd9; job_simple_mul = 1'b0; job_iter = 16'd0;
        job_valid = 1'b1; soft_clear = 1'b1; d_valid = 1'b1;
        #1;
        check("sc_abort_clear", {31'd0, eng_clear}, 32'd1);
        check("sc_abort_not_ready", {31'd0, job_ready}, 32'd0);
        tick();
        soft_clear = 1'b0; d_valid = 1'b0;
        #1;
        check("sc_abort_iter", {16'd0, iter_left}, 32'd0);
        check("sc_abort_idle", {30'd0, busy, done}, 32'd0);
        check("sc_abort_len_kept", {24'd0, eng_len}, 32'd4);
        check("sc_abort_ready_next", {31'd0, job_ready}, 32'd1);
        tick();
        job_valid = 1'b0;
        check("sc_abort_accepted", {24'd0, eng_len}, 32'd7);
        check("sc_abort_new_done", {31'd0, done}, 32'd1);
        tick();
        check("sc_abort_no_done", dones, 32'd1);

`ifdef MAC_SEQ_PERF_CNT_EN
        // Perf counter: scalar len=4 iter=1, no stalls
        en_cycles = 0;
        issue(8'd4, 5'd0, 1'b0, 16'd1);
        check("perf_cleared", perf_cycles, 32'd0);
        tick(); tick(); tick(); tick();
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        check("perf_done", {31'd0, done}, 32'd1);
        check("perf_vs_enable", perf_cycles, en_cycles);
        check("perf_value", perf_cycles, 32'd4);
        tick(); tick();
        check("perf_held", perf_cycles, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
